// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: format exponent widths, the
// binary32 exponent-adjust beat bundle and an all-ones exponent helper.
package fp_pkg;

    localparam int FP32_EXP_W  = 8;
    localparam int FP64_EXP_W  = 11;
    localparam int FP32_LOPD_W = 8;
    localparam int EXP_MAX_W   = 16;

    // One exponent-adjust request in the default (binary32) format.
    typedef struct packed {
        logic                   overflow;
        logic                   underflow;
        logic                   zero;
        logic                   rnd_carry;
        logic [FP32_LOPD_W-1:0] lopd;
        logic [FP32_EXP_W-1:0]  exp;
    } exp_adj_in_t;

    // Low exp_w bits set: the Inf/NaN biased exponent for that format.
    function automatic logic [EXP_MAX_W-1:0] exp_all_ones(input int unsigned exp_w);
        logic [EXP_MAX_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < EXP_MAX_W; i++) begin
            if (i < int'(exp_w)) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/exp_adjust_sat.sv
// Combinational saturate/flush of a signed exponent sum into a biased exponent
// with overflow (Inf) and underflow (flush-to-zero) flags.
module exp_adjust_sat
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W
) (
    input  logic [EXP_W+1:0] sum,
    input  logic             zero,
    output logic [EXP_W-1:0] exp_result,
    output logic             ovf,
    output logic             unf
);

    localparam logic [EXP_W-1:0] ALL_ONES = EXP_W'(exp_all_ones(EXP_W));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        exp_result = '0;
        ovf        = 1'b0;
        unf        = 1'b0;
        if (!zero) begin
            // sum is two's complement: the top bit set means a negative exponent.
            if (sum[EXP_W+1] || (sum == '0)) begin
                unf = 1'b1;
            end else if (sum[EXP_W:0] >= {1'b0, ALL_ONES}) begin
                exp_result = ALL_ONES;
                ovf        = 1'b1;
            end else begin
                exp_result = sum[EXP_W-1:0];
            end
        end
    end

endmodule

// File: rtl/exp_adjust_pipe.sv
// Two-stage exponent-adjust pipeline for the FP add/sub datapath with a
// bubble-free valid/ready chain and a saturating exception-event counter.
module exp_adjust_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP32_EXP_W,
    parameter int LOPD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_overflow,
    input  logic              i_underflow,
    input  logic              i_zero_flag,
    input  logic              i_rnd_carry,
    input  logic [LOPD_W-1:0] i_lopd_value,
    input  logic [EXP_W-1:0]  i_exp_value,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp_result,
    output logic              o_ovf,
    output logic              o_unf,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_evt_cnt
);

    // Two extra bits hold the +2 carry headroom and the sign of exp - lopd.
    localparam int SUM_W = EXP_W + 2;

    logic             v1;
    logic             v2;
    logic             rdy1;
    logic             rdy2;
    logic [SUM_W-1:0] s1_sum;
    logic             s1_zero;
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] delta;
    logic [SUM_W-1:0] sum_next;
    logic [EXP_W-1:0] sat_exp;
    logic             sat_ovf;
    logic             sat_unf;

    assign rdy2    = ~v2 | i_ready;
    assign rdy1    = ~v1 | rdy2;
    assign o_ready = rdy1;
    assign o_valid = v2;

    // Mantissa carry-out takes priority over the no-shift case.
    always_comb begin
        inc   = '0;
        delta = '0;
        if (i_overflow) begin
            inc = SUM_W'(1);
        end else if (!i_underflow) begin
            delta = SUM_W'(i_lopd_value);
        end
        sum_next = SUM_W'(i_exp_value) + inc + SUM_W'(i_rnd_carry) - delta;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: datapath registers are reset too; they feed outputs whose reset value is visible.
            v1      <= 1'b0;
            s1_sum  <= '0;
            s1_zero <= 1'b0;
        end else if (rdy1) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            v1 <= i_valid;
            if (i_valid) begin
                s1_sum  <= sum_next;
                s1_zero <= i_zero_flag;
            end
        end
    end

    exp_adjust_sat #(
        .EXP_W (EXP_W)
    ) u_sat (
        .sum        (s1_sum),
        .zero       (s1_zero),
        .exp_result (sat_exp),
        .ovf        (sat_ovf),
        .unf        (sat_unf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2           <= 1'b0;
            o_exp_result <= '0;
            o_ovf        <= 1'b0;
            o_unf        <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                o_exp_result <= sat_exp;
                o_ovf        <= sat_ovf;
                o_unf        <= sat_unf;
            end
        end
    end

    // Counts exceptional results as they leave; clear wins over a same-cycle event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_evt_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_evt_cnt <= '0;
        end else if (v2 && i_ready && (o_ovf || o_unf) && (o_evt_cnt != '1)) begin
            o_evt_cnt <= o_evt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Self-checking bench for exp_adjust_pipe: directed cases, backpressure, counter
// clear/saturation and reset, plus random traffic against an arithmetic model.
module tb_exp_adjust_pipe;
    import fp_pkg::*;

    localparam int EXP_W   = 8;
    localparam int LOPD_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic              i_overflow;
    logic              i_underflow;
    logic              i_zero_flag;
    logic              i_rnd_carry;
    logic [LOPD_W-1:0] i_lopd_value;
    logic [EXP_W-1:0]  i_exp_value;
    logic              o_valid;
    logic              i_ready;
    logic [EXP_W-1:0]  o_exp_result;
    logic              o_ovf;
    logic              o_unf;
    logic              i_cnt_clr;
    logic [CNT_W-1:0]  o_evt_cnt;

    exp_adjust_pipe #(
        .EXP_W  (EXP_W),
        .LOPD_W (LOPD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_overflow   (i_overflow),
        .i_underflow  (i_underflow),
        .i_zero_flag  (i_zero_flag),
        .i_rnd_carry  (i_rnd_carry),
        .i_lopd_value (i_lopd_value),
        .i_exp_value  (i_exp_value),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_exp_result (o_exp_result),
        .o_ovf        (o_ovf),
        .o_unf        (o_unf),
        .i_cnt_clr    (i_cnt_clr),
        .o_evt_cnt    (o_evt_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [EXP_W-1:0] exp;
        logic             ovf;
        logic             unf;
    } res_t;

    res_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          model_cnt = 0;
    logic        last_acc  = 1'b0;
    logic        prev_stall = 1'b0;
    res_t        held;
    exp_adj_in_t cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Plain integer arithmetic straight from the exponent-adjust rules.
    function automatic res_t model(input exp_adj_in_t b);
        res_t r;
        int   s;
        s = int'(b.exp) + int'(b.rnd_carry);
        if (b.overflow)        s = s + 1;
        else if (!b.underflow) s = s - int'(b.lopd);
        r.exp = '0;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (b.zero) begin
        end else if (s <= 0) begin
            r.unf = 1'b1;
        end else if (s >= 255) begin
            r.exp = 8'hFF;
            r.ovf = 1'b1;
        end else begin
            r.exp = s[7:0];
        end
        return r;
    endfunction

    function automatic exp_adj_in_t mk(input logic [7:0] e, input logic [7:0] l,
                                       input logic ov, input logic un,
                                       input logic z, input logic rc);
        exp_adj_in_t b;
        b.exp = e; b.lopd = l; b.overflow = ov; b.underflow = un;
        b.zero = z; b.rnd_carry = rc;
        return b;
    endfunction

    task automatic apply(input exp_adj_in_t b);
        cur          = b;
        i_exp_value  = b.exp;
        i_lopd_value = b.lopd;
        i_overflow   = b.overflow;
        i_underflow  = b.underflow;
        i_zero_flag  = b.zero;
        i_rnd_carry  = b.rnd_carry;
    endtask

    // One clock: sample on the falling edge, score, then step past the rising edge.
    task automatic tick();
        res_t e;
        logic ohs;
        @(negedge i_clk);
        check("o_ready", o_ready, (sb.size() < 2) || i_ready);
        if (prev_stall) begin
            check("stall_valid", o_valid, 1'b1);
            check("stall_exp", o_exp_result, held.exp);
            check("stall_ovf", o_ovf, held.ovf);
            check("stall_unf", o_unf, held.unf);
        end
        check("evt_cnt", o_evt_cnt, model_cnt);
        last_acc = i_valid && o_ready;
        ohs      = o_valid && i_ready;
        if (ohs) begin
            if (sb.size() == 0) begin
                check("spurious_beat", o_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("exp_result", o_exp_result, e.exp);
                check("ovf", o_ovf, e.ovf);
                check("unf", o_unf, e.unf);
                if (!i_cnt_clr && (e.ovf || e.unf) && model_cnt < CNT_MAX) model_cnt++;
            end
        end
        if (i_cnt_clr) model_cnt = 0;
        if (last_acc) sb.push_back(model(cur));
        prev_stall = o_valid && !i_ready;
        held.exp   = o_exp_result;
        held.ovf   = o_ovf;
        held.unf   = o_unf;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input exp_adj_in_t b);
        apply(b);
        i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_acc) break;
        end
        check("send_accept", last_acc, 1'b1);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        for (int k = 0; k < 30 && sb.size() > 0; k++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_cnt_clr = 1'b0;
        apply(mk(8'h00, 8'h00, 0, 0, 0, 0));
        #12;
        check("rst_valid", o_valid, 1'b0);
        check("rst_exp", o_exp_result, 0);
        check("rst_ovf", o_ovf, 1'b0);
        check("rst_unf", o_unf, 1'b0);
        check("rst_cnt", o_evt_cnt, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Normalise, with the two-cycle latency observed directly.
        apply(mk(8'h80, 8'd3, 0, 0, 0, 0));
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("lat_cycle1", o_valid, 1'b0);
        tick();
        check("lat_cycle2", o_valid, 1'b1);
        check("norm_exp", o_exp_result, 8'h7D);
        drain();

        send(mk(8'hFD, 8'd0, 1, 0, 0, 1));
        drain();
        check("cnt_after_ovf", o_evt_cnt, 1);

        send(mk(8'h03, 8'd5, 0, 0, 0, 0));
        send(mk(8'h05, 8'd5, 0, 0, 0, 0));
        send(mk(8'h06, 8'd5, 0, 0, 0, 0));
        send(mk(8'h10, 8'd7, 1, 1, 0, 0));
        send(mk(8'h10, 8'd7, 1, 1, 1, 0));
        drain();
        check("cnt_after_unf", o_evt_cnt, 3);

        // Backpressure: two beats fill the pipe, the third waits.
        i_ready = 1'b0;
        send(mk(8'h40, 8'd1, 0, 0, 0, 0));
        send(mk(8'h40, 8'd2, 0, 0, 0, 0));
        apply(mk(8'h40, 8'd3, 0, 0, 0, 0));
        i_valid = 1'b1;
        tick();
        check("bp_ready_low", o_ready, 1'b0);
        check("bp_no_accept", last_acc, 1'b0);
        tick();
        i_ready = 1'b1;
        send(mk(8'h40, 8'd3, 0, 0, 0, 0));
        send(mk(8'h40, 8'd4, 0, 0, 0, 0));
        drain();

        // Clear coinciding with the third overflow handshake.
        send(mk(8'hFF, 8'd0, 1, 0, 0, 0));
        send(mk(8'hFF, 8'd0, 1, 0, 0, 0));
        send(mk(8'hFF, 8'd0, 1, 0, 0, 0));
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 1 && o_valid) break;
            tick();
        end
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        check("clr_wins", o_evt_cnt, 0);
        drain();

        // Random traffic with random backpressure and occasional clears.
        for (int n = 0; n < 400; n++) begin
            exp_adj_in_t b;
            b.exp       = 8'($urandom_range(0, 255));
            b.lopd      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 20));
            b.overflow  = ($urandom_range(0, 3) == 0);
            b.underflow = ($urandom_range(0, 3) == 0);
            b.zero      = ($urandom_range(0, 7) == 0);
            b.rnd_carry = ($urandom_range(0, 3) == 0);
            apply(b);
            i_valid   = ($urandom_range(0, 3) != 0);
            i_ready   = ($urandom_range(0, 2) != 0);
            i_cnt_clr = ($urandom_range(0, 39) == 0);
            tick();
        end
        i_cnt_clr = 1'b0;
        i_ready   = 1'b1;
        drain();

        // Reset with two beats in flight discards them.
        i_ready = 1'b0;
        send(mk(8'h20, 8'd1, 0, 0, 0, 0));
        send(mk(8'hFF, 8'd0, 1, 0, 0, 0));
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_exp", o_exp_result, 0);
        check("midrst_cnt", o_evt_cnt, 0);
        sb.delete();
        model_cnt  = 0;
        prev_stall = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("no_stale_beat", o_valid, 1'b0);
        send(mk(8'h30, 8'd2, 0, 0, 0, 1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_adjust_pipe.md
Name: exp_adjust_pipe

Overview:
- Exponent-adjust stage for the FP add/sub datapath, successor of the combinational exponent adjuster.
- Takes the pre-normalisation exponent, the leading-one position (LOPD) and the mantissa overflow/underflow/zero/round-carry flags, and produces the final biased exponent.
- Exponent and LOPD widths are parametrised; output saturates to Inf on overflow and flushes to zero on underflow, with flags.
- Two-stage registered pipeline with valid/ready handshake, plus a saturating exception-event counter.

Parameters:
- EXP_W, 8, exponent width (8 = binary32, 11 = binary64).
- LOPD_W, 8, width of the leading-one shift amount; must satisfy LOPD_W <= EXP_W+1.
- CNT_W, 16, width of the exception-event counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  stage can accept a beat
- i_overflow  in  1  mantissa carried out, so exponent +1
- i_underflow  in  1  no normalisation shift, so exponent unchanged
- i_zero_flag  in  1  result mantissa is zero
- i_rnd_carry  in  1  rounding carried into the hidden bit, so exponent +1 extra
- i_lopd_value  in  LOPD_W  left-shift amount applied to the mantissa
- i_exp_value  in  EXP_W  biased exponent before adjustment
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_exp_result  out  EXP_W  adjusted biased exponent
- o_ovf  out  1  result saturated to all-ones (Inf)
- o_unf  out  1  result flushed to zero
- i_cnt_clr  in  1  synchronous clear of the event counter
- o_evt_cnt  out  CNT_W  count of accepted beats with o_ovf or o_unf set

Behaviour:
- Reset (async assert, sync deassert assumed external): o_valid=0, o_exp_result=0, o_ovf=0, o_unf=0, o_evt_cnt=0, both stage valids=0. Reset mid-operation discards all in-flight beats.
- Handshake:
  - rdy2 = ~v2 | i_ready; rdy1 = ~v1 | rdy2; o_ready = rdy1 (combinational chain, no bubbles).
  - Beat accepted when i_valid & o_ready.
  - Outputs are held stable while o_valid & ~i_ready.
- Latency: 2 cycles from acceptance to o_valid with no stalls; throughput 1 beat/cycle.
- Stage 1 registers a signed sum S of width EXP_W+2:
  - S = zext(i_exp_value) + inc + i_rnd_carry - delta.
  - i_overflow=1: inc=1, delta=0. This has priority when both i_overflow and i_underflow are set.
  - else i_underflow=1: inc=0, delta=0.
  - else: inc=0, delta=zext(i_lopd_value).
  - Stage 1 also registers the zero flag.
- Stage 2 registers the result:
  - zero flag set: o_exp_result=0, o_ovf=0, o_unf=0, regardless of S.
  - else if S <= 0 (sign bit set or S==0): o_exp_result=0, o_unf=1.
  - else if S >= 2^EXP_W-1: o_exp_result = all-ones, o_ovf=1.
  - else: o_exp_result = S[EXP_W-1:0], both flags 0.
- Counter:
  - Increments by 1 on each output handshake (o_valid & i_ready) with o_ovf|o_unf.
  - Saturates at all-ones and never wraps.
  - i_cnt_clr sets it to 0. If i_cnt_clr coincides with an increment, clear wins.
- No state is updated by beats that are not accepted; stalled stages hold their contents.

Decomposition:
- Shared package fp_pkg:
  - EXP_W defaults per format (FP32_EXP_W=8, FP64_EXP_W=11).
  - Function exp_all_ones(EXP_W).
  - Packed struct exp_adj_in_t {overflow, underflow, zero, rnd_carry, lopd, exp} for stage-1 registers.
- One sub-module is natural: exp_adjust_sat, a combinational stage-2 saturate/flush plus flag logic, reusable in the multiplier path.
- The EXP_W+2 adder stays inline; the CLA_8bit instance is not reused because the width is parametrised.

Test Plan (EXP_W=8, LOPD_W=8):
- Normalise: exp=0x80, lopd=3, flags 0 -> after 2 cycles o_exp_result=0x7D, o_ovf=0, o_unf=0.
- Overflow with round carry: exp=0xFD, i_overflow=1, i_rnd_carry=1 -> S=0xFF, so o_exp_result=0xFF, o_ovf=1, counter 0->1.
- Underflow on shift: exp=0x03, lopd=5 -> S=-2, so o_exp_result=0x00, o_unf=1. exp=0x05, lopd=5 -> o_unf=1. exp=0x06, lopd=5 -> 0x01, no flag.
- Priority and zero: i_overflow=i_underflow=1, exp=0x10 -> 0x11. Then same beat with i_zero_flag=1 -> 0x00, no flags, counter unchanged.
- Backpressure: stream 4 beats with i_ready held low for 3 cycles -> o_ready drops after 2 beats are held; outputs stay stable while stalled; all 4 results emerge in order with no loss or duplication.
- Counter and reset: force 3 ovf beats with i_cnt_clr asserted on the 3rd handshake -> o_evt_cnt=0. Assert i_rst_n=0 with beats in flight -> o_valid=0 immediately; no stale beat after release.
